multi_channel_watchdog: RTL and testbench
=========================================

Name: multi_channel_watchdog

Overview:
N-channel generalisation of the single-channel watchdog timer. Each channel has its own heartbeat, enable, clear and force-trip inputs, and its own counter and state machine. Warning and trip thresholds are parameters, and trip is sticky until explicitly cleared. Sits beside the AM-radio control logic; aggregated trip feeds the system-reset/alarm path.

Parameters:
NUM_CH, 4, number of independent channels (1..16)
CNT_W, 32, counter width per channel
TIMEOUT, 1000, cycles without a kick until trip; 2 <= TIMEOUT < 2^CNT_W
WARN_AT, 750, counter value at which warning asserts; 1 <= WARN_AT < TIMEOUT
MIN_KICK, 10, earliest legal kick count; used only with WD_WINDOW_EN; MIN_KICK < WARN_AT

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
enable  in  NUM_CH  per-channel enable (level)
heartbeat  in  NUM_CH  per-channel kick; each high cycle is one kick
clear  in  NUM_CH  per-channel trip acknowledge (level, sampled)
force_trip  in  NUM_CH  per-channel immediate trip request (test/abort)
warn  out  NUM_CH  per-channel warning, registered
trip  out  NUM_CH  per-channel sticky trip, registered
any_trip  out  1  registered OR of trip
trip_count  out  8  saturating count of trip events, all channels
early_kick  out  NUM_CH  window-violation flag (tied 0 without WD_WINDOW_EN)

Behaviour:
- Reset (rstn low, async): all channels DISABLED, counters 0. warn, trip, any_trip, early_kick and trip_count are 0.
- Per-channel FSM states: DISABLED, RUNNING, WARNING, TRIPPED.
- Per-edge priority, highest first:
  1. enable low -> DISABLED, counter 0, warn/trip/early_kick cleared. This includes leaving TRIPPED.
  2. clear high while TRIPPED -> RUNNING, counter 0, trip cleared. Ignored in other states.
  3. force_trip high in RUNNING or WARNING -> TRIPPED; counter holds.
  4. heartbeat high in RUNNING or WARNING -> RUNNING, counter 0, warn cleared.
  5. Otherwise, in RUNNING or WARNING, counter increments by 1.
- DISABLED with enable high -> RUNNING, counter 0 on that edge.
- Counter reaching WARN_AT (after increment) -> WARNING, warn=1 on the same edge.
- Counter reaching TIMEOUT -> TRIPPED, trip=1, warn stays 1. Counter saturates at TIMEOUT and never wraps.
- In TRIPPED: heartbeat and force_trip are ignored. Only clear or enable low exits.
- Latency (no kick, from entry to RUNNING): warn high after WARN_AT edges; trip high after TIMEOUT edges.
- any_trip is registered: it follows OR(trip) one cycle later.
- trip_count increments by the number of channels entering TRIPPED on that edge, saturating at 255. It clears only on rstn.
- Simultaneous clear and heartbeat on a TRIPPED channel: clear wins; heartbeat is ignored that edge.
- Channels are fully independent; there is no shared state except any_trip and trip_count.

Optional Feature:
Macro: WD_WINDOW_EN.
- Defined: windowed watchdog.
  - A heartbeat in RUNNING with counter < MIN_KICK is an early kick. The channel goes TRIPPED and early_kick[ch]=1 (sticky until clear or enable low).
  - Early-kick priority sits between force_trip and the normal heartbeat.
- Undefined: any heartbeat is valid, MIN_KICK is unused, and early_kick is constant 0.

Test Plan:
(All cases use NUM_CH=2, TIMEOUT=8, WARN_AT=6, MIN_KICK=2.)
1. Reset, then enable=2'b01 with no heartbeat -> ch0 warn=1 at edge 6 after RUNNING entry, trip=1 at edge 8, any_trip=1 one cycle later; ch1 stays 0; trip_count=1.
2. ch0 heartbeat every 5 cycles for 40 cycles -> warn and trip stay 0; counter never exceeds 5.
3. Let ch0 reach TRIPPED, then pulse heartbeat -> trip stays 1. Pulse clear -> trip=0, counter 0, RUNNING; re-trips 8 cycles later and trip_count=2.
4. force_trip on both channels in the same cycle -> both trip=1 next edge, trip_count +2. Hold force_trip for 300 trips total -> trip_count saturates at 255.
5. Deassert rstn mid-count (ch0 counter=5, warn low) -> all outputs 0 immediately, asynchronously; after release, counting restarts from 0.
6. With WD_WINDOW_EN: heartbeat at counter=1 -> trip=1, early_kick=1; heartbeat at counter=3 -> normal kick. Without the macro, the counter=1 kick is a normal kick and early_kick=0.

Source files
------------

// File: rtl/multi_channel_watchdog_if.sv
// Control and status bundle for multi_channel_watchdog.
//   enable, heartbeat, clear, force_trip : per-channel controls into the watchdog
//   warn, trip, early_kick               : per-channel registered status
//   any_trip                             : registered OR of trip
//   trip_count                           : saturating count of trip events
// The master modport belongs to whoever drives the controls.
// The slave modport belongs to the watchdog itself.
interface multi_channel_watchdog_if #(
  parameter int unsigned NUM_CH = 4
);
  logic [NUM_CH-1:0] enable;
  logic [NUM_CH-1:0] heartbeat;
  logic [NUM_CH-1:0] clear;
  logic [NUM_CH-1:0] force_trip;
  logic [NUM_CH-1:0] warn;
  logic [NUM_CH-1:0] trip;
  logic [NUM_CH-1:0] early_kick;
  logic              any_trip;
  logic [7:0]        trip_count;

  modport master (
    output enable, heartbeat, clear, force_trip,
    input  warn, trip, early_kick, any_trip, trip_count
  );

  modport slave (
    input  enable, heartbeat, clear, force_trip,
    output warn, trip, early_kick, any_trip, trip_count
  );
endinterface

// File: rtl/multi_channel_watchdog.sv
// N-channel watchdog timer. Each channel counts cycles since its last heartbeat.
// - warn asserts when the count reaches WARN_AT.
// - trip asserts when the count reaches TIMEOUT, and is sticky until clear or enable low.
// - force_trip trips a running channel at once.
// - any_trip is the OR of trip, delayed by one register stage.
// - trip_count sums channel trip entries and saturates at 255.
//
// Ports:
//   clk  : system clock
//   rstn : asynchronous active-low reset
//   wd   : multi_channel_watchdog_if.slave, carrying the controls and status
//
// Optional build macro WD_WINDOW_EN enables the windowed watchdog.
// With it, a heartbeat in RUNNING while the counter is below MIN_KICK trips the
// channel and sets early_kick. Without it, early_kick is tied to 0.
module multi_channel_watchdog #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned TIMEOUT  = 1000,
  parameter int unsigned WARN_AT  = 750,
  parameter int unsigned MIN_KICK = 10
) (
  input  logic                    clk,
  input  logic                    rstn,
  multi_channel_watchdog_if.slave wd
);

  // Elaboration-time parameter sanity check
  if (NUM_CH < 1 || NUM_CH > 16 || TIMEOUT < 2 || WARN_AT < 1 || WARN_AT >= TIMEOUT ||
      MIN_KICK >= WARN_AT) begin : gen_param_err
    $error("multi_channel_watchdog: illegal parameter combination");
  end

  localparam logic [CNT_W-1:0] TimeoutC = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] WarnC    = CNT_W'(WARN_AT);
  localparam logic [CNT_W-1:0] OneC     = CNT_W'(1);
`ifdef WD_WINDOW_EN
  localparam logic [CNT_W-1:0] MinKickC = CNT_W'(MIN_KICK);
`endif

  typedef enum logic [1:0] {
    StDisabled,
    StRunning,
    StWarning,
    StTripped
  } state_e;

  state_e            st_q  [NUM_CH];
  state_e            st_d  [NUM_CH];
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [NUM_CH-1:0] warn_q, warn_d;
  logic [NUM_CH-1:0] trip_q, trip_d;
  logic [NUM_CH-1:0] ek_q, ek_d;
  logic [NUM_CH-1:0] enter_trip;
  logic              any_trip_q, any_trip_d;
  logic [7:0]        tc_q, tc_d;
  logic [4:0]        entered;
  logic [8:0]        tc_sum;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        st_q[i]  <= StDisabled;
        cnt_q[i] <= '0;
      end
      warn_q     <= '0;
      trip_q     <= '0;
      ek_q       <= '0;
      any_trip_q <= 1'b0;
      tc_q       <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      warn_q     <= warn_d;
      trip_q     <= trip_d;
      ek_q       <= ek_d;
      any_trip_q <= any_trip_d;
      tc_q       <= tc_d;
    end
  end

  // Per-channel next state
  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      st_d[i]       = st_q[i];
      cnt_d[i]      = cnt_q[i];
      warn_d[i]     = warn_q[i];
      trip_d[i]     = trip_q[i];
      ek_d[i]       = ek_q[i];
      enter_trip[i] = 1'b0;

      if (!wd.enable[i]) begin
        st_d[i]   = StDisabled;
        cnt_d[i]  = '0;
        warn_d[i] = 1'b0;
        trip_d[i] = 1'b0;
        ek_d[i]   = 1'b0;
      end else begin
        case (st_q[i])
          StDisabled: begin
            st_d[i]  = StRunning;
            cnt_d[i] = '0;
          end
          StTripped: begin
            // Only clear leaves TRIPPED; heartbeat and force_trip are ignored here
            if (wd.clear[i]) begin
              st_d[i]   = StRunning;
              cnt_d[i]  = '0;
              trip_d[i] = 1'b0;
              warn_d[i] = 1'b0;
              ek_d[i]   = 1'b0;
            end
          end
          StRunning, StWarning: begin
            if (wd.force_trip[i]) begin
              st_d[i]       = StTripped;
              trip_d[i]     = 1'b1;
              enter_trip[i] = 1'b1;
            end
`ifdef WD_WINDOW_EN
            else if (wd.heartbeat[i] && (st_q[i] == StRunning) && (cnt_q[i] < MinKickC)) begin
              st_d[i]       = StTripped;
              trip_d[i]     = 1'b1;
              ek_d[i]       = 1'b1;
              enter_trip[i] = 1'b1;
            end
`endif
            else if (wd.heartbeat[i]) begin
              st_d[i]   = StRunning;
              cnt_d[i]  = '0;
              warn_d[i] = 1'b0;
            end else if ((cnt_q[i] + OneC) == TimeoutC) begin
              // The counter stops at TIMEOUT and holds there while TRIPPED
              st_d[i]       = StTripped;
              cnt_d[i]      = TimeoutC;
              trip_d[i]     = 1'b1;
              warn_d[i]     = 1'b1;
              enter_trip[i] = 1'b1;
            end else begin
              cnt_d[i] = cnt_q[i] + OneC;
              if ((cnt_q[i] + OneC) >= WarnC) begin
                st_d[i]   = StWarning;
                warn_d[i] = 1'b1;
              end
            end
          end
          default: begin
            st_d[i]  = StDisabled;
            cnt_d[i] = '0;
          end
        endcase
      end
    end
  end

  // Shared status: any_trip lags trip by one register stage; trip_count saturates
  always_comb begin
    entered = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      entered = entered + 5'(enter_trip[i]);
    end
    tc_sum     = {1'b0, tc_q} + 9'(entered);
    tc_d       = (tc_sum > 9'd255) ? 8'hFF : tc_sum[7:0];
    any_trip_d = |trip_q;
  end

  // Outputs
  always_comb begin
    wd.warn       = warn_q;
    wd.trip       = trip_q;
    wd.any_trip   = any_trip_q;
    wd.trip_count = tc_q;
`ifdef WD_WINDOW_EN
    wd.early_kick = ek_q;
`else
    wd.early_kick = '0;
`endif
  end

endmodule

// File: tb/tb_multi_channel_watchdog.sv
// Self-checking bench for multi_channel_watchdog (NUM_CH=2, TIMEOUT=8, WARN_AT=6, MIN_KICK=2).
module tb_multi_channel_watchdog;
  localparam int unsigned NCH = 2;
  localparam int unsigned CW  = 8;
  localparam int          TO  = 8;
  localparam int          WA  = 6;
  localparam int          MK  = 2;
`ifdef WD_WINDOW_EN
  localparam bit Window = 1'b1;
`else
  localparam bit Window = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  multi_channel_watchdog_if #(.NUM_CH(NCH)) wif ();

  multi_channel_watchdog #(
    .NUM_CH  (NCH),
    .CNT_W   (CW),
    .TIMEOUT (TO),
    .WARN_AT (WA),
    .MIN_KICK(MK)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .wd  (wif.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: age = cycles since last kick/entry, flags per channel
  bit m_on [NCH];
  int m_age[NCH];
  bit m_tr [NCH];
  bit m_wn [NCH];
  bit m_ek [NCH];
  int m_tc;
  bit m_any;

  typedef struct {
    logic [1:0] en;
    logic [1:0] hb;
    logic [1:0] clr;
    logic [1:0] ft;
    logic [1:0] warn;
    logic [1:0] trip;
    logic       any;
    logic [7:0] tc;
  } vec_t;
  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_on[c] = 0; m_age[c] = 0; m_tr[c] = 0; m_wn[c] = 0; m_ek[c] = 0;
    end
    m_tc  = 0;
    m_any = 0;
  endtask

  // Called at the clock edge with the inputs the DUT is sampling
  task automatic model_step();
    int entered = 0;
    bit old_or  = 0;
    for (int c = 0; c < NCH; c++) old_or |= m_tr[c];
    for (int c = 0; c < NCH; c++) begin
      if (!wif.enable[c]) begin
        m_on[c] = 0; m_age[c] = 0; m_tr[c] = 0; m_wn[c] = 0; m_ek[c] = 0;
      end else if (!m_on[c]) begin
        m_on[c] = 1; m_age[c] = 0;
      end else if (m_tr[c]) begin
        if (wif.clear[c]) begin
          m_tr[c] = 0; m_age[c] = 0; m_wn[c] = 0; m_ek[c] = 0;
        end
      end else if (wif.force_trip[c]) begin
        m_tr[c] = 1; entered++;
      end else if (Window && wif.heartbeat[c] && !m_wn[c] && m_age[c] < MK) begin
        m_tr[c] = 1; m_ek[c] = 1; entered++;
      end else if (wif.heartbeat[c]) begin
        m_age[c] = 0; m_wn[c] = 0;
      end else begin
        m_age[c]++;
        if (m_age[c] >= WA) m_wn[c] = 1;
        if (m_age[c] == TO) begin
          m_tr[c] = 1; entered++;
        end
      end
    end
    m_tc  = (m_tc + entered > 255) ? 255 : m_tc + entered;
    m_any = old_or;
  endtask

  task automatic model_check(input string tag);
    logic [NCH-1:0] w, t, e;
    for (int c = 0; c < NCH; c++) begin
      w[c] = m_wn[c]; t[c] = m_tr[c]; e[c] = m_ek[c];
    end
    chk({tag, " warn"}, 32'(wif.warn), 32'(w));
    chk({tag, " trip"}, 32'(wif.trip), 32'(t));
    chk({tag, " early_kick"}, 32'(wif.early_kick), 32'(e));
    chk({tag, " any_trip"}, 32'(wif.any_trip), 32'(m_any));
    chk({tag, " trip_count"}, 32'(wif.trip_count), 32'(m_tc));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_in(input logic [1:0] en, input logic [1:0] hb, input logic [1:0] clr,
                        input logic [1:0] ft);
    wif.enable = en; wif.heartbeat = hb; wif.clear = clr; wif.force_trip = ft;
  endtask

  task automatic do_reset();
    set_in(2'b00, 2'b00, 2'b00, 2'b00);
    rstn = 1'b0;
    model_reset();
    #2;
    rstn = 1'b1;
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout simulation did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    for (int i = 0; i < 11; i++) begin
      vecs[i] = '{en: 2'b01, hb: 2'b00, clr: 2'b00, ft: 2'b00,
                  warn: (i >= WA) ? 2'b01 : 2'b00, trip: (i >= TO) ? 2'b01 : 2'b00,
                  any: (i >= TO + 1), tc: (i >= TO) ? 8'd1 : 8'd0};
    end

    // Reset state
    set_in(2'b00, 2'b00, 2'b00, 2'b00);
    rstn = 1'b0;
    model_reset();
    #12;
    chk("reset warn", 32'(wif.warn), 0);
    chk("reset trip", 32'(wif.trip), 0);
    chk("reset any_trip", 32'(wif.any_trip), 0);
    chk("reset trip_count", 32'(wif.trip_count), 0);
    chk("reset early_kick", 32'(wif.early_kick), 0);
    @(negedge clk);
    rstn = 1'b1;

    // Test 1: ch0 runs unkicked to trip; table row i is edge i after entry
    for (int i = 0; i < 11; i++) begin
      set_in(vecs[i].en, vecs[i].hb, vecs[i].clr, vecs[i].ft);
      tick();
      chk($sformatf("t1[%0d] warn", i), 32'(wif.warn), 32'(vecs[i].warn));
      chk($sformatf("t1[%0d] trip", i), 32'(wif.trip), 32'(vecs[i].trip));
      chk($sformatf("t1[%0d] any_trip", i), 32'(wif.any_trip), 32'(vecs[i].any));
      chk($sformatf("t1[%0d] trip_count", i), 32'(wif.trip_count), 32'(vecs[i].tc));
    end

    // Test 3: heartbeat ignored while tripped, clear restarts, re-trip after TIMEOUT
    set_in(2'b01, 2'b01, 2'b00, 2'b00);
    tick();
    chk("t3 hb ignored trip", 32'(wif.trip), 32'h1);
    set_in(2'b01, 2'b01, 2'b01, 2'b00);  // clear wins over heartbeat
    tick();
    chk("t3 cleared trip", 32'(wif.trip), 32'h0);
    chk("t3 cleared warn", 32'(wif.warn), 32'h0);
    set_in(2'b01, 2'b00, 2'b00, 2'b00);
    for (int k = 1; k <= TO; k++) begin
      tick();
      chk($sformatf("t3 retrip k=%0d", k), 32'(wif.trip), (k == TO) ? 32'h1 : 32'h0);
    end
    chk("t3 trip_count", 32'(wif.trip_count), 32'd2);

    // Test 2: periodic heartbeat keeps ch0 quiet
    do_reset();
    set_in(2'b01, 2'b00, 2'b00, 2'b00);
    tick();
    for (int c = 1; c <= 40; c++) begin
      set_in(2'b01, (c % 5 == 0) ? 2'b01 : 2'b00, 2'b00, 2'b00);
      tick();
      chk("t2 warn", 32'(wif.warn), 0);
      chk("t2 trip", 32'(wif.trip), 0);
    end

    // Test 4: simultaneous force trip, then saturate trip_count
    do_reset();
    set_in(2'b11, 2'b00, 2'b00, 2'b00);
    tick();
    set_in(2'b11, 2'b00, 2'b00, 2'b11);
    tick();
    chk("t4 both trip", 32'(wif.trip), 32'h3);
    chk("t4 trip_count", 32'(wif.trip_count), 32'd2);
    // Holding clear and force together alternates TRIPPED/RUNNING each edge
    set_in(2'b11, 2'b00, 2'b11, 2'b11);
    for (int c = 0; c < 300; c++) begin
      tick();
      model_check("t4 sat");
    end
    chk("t4 saturated", 32'(wif.trip_count), 32'd255);

    // Test 5: async reset mid-count
    set_in(2'b11, 2'b00, 2'b00, 2'b00);
    tick();  // any tripped channel stays tripped, the rest keep running
    set_in(2'b00, 2'b00, 2'b00, 2'b00);
    tick();
    set_in(2'b11, 2'b00, 2'b00, 2'b00);
    tick();  // entry, ch0 counter 0
    set_in(2'b11, 2'b00, 2'b00, 2'b10);
    tick();  // ch1 trips, ch0 counter 1
    set_in(2'b11, 2'b00, 2'b00, 2'b00);
    for (int c = 0; c < 4; c++) tick();  // ch0 counter 5
    chk("t5 pre trip", 32'(wif.trip), 32'h2);
    chk("t5 pre warn", 32'(wif.warn), 32'h0);
    #2;
    rstn = 1'b0;
    model_reset();
    #1;
    chk("t5 async warn", 32'(wif.warn), 0);
    chk("t5 async trip", 32'(wif.trip), 0);
    chk("t5 async any_trip", 32'(wif.any_trip), 0);
    chk("t5 async trip_count", 32'(wif.trip_count), 0);
    @(negedge clk);
    rstn = 1'b1;
    tick();  // entry
    for (int k = 1; k <= WA; k++) begin
      tick();
      chk($sformatf("t5 restart warn k=%0d", k), 32'(wif.warn), (k == WA) ? 32'h3 : 32'h0);
    end

    // Test 6: kick at counter 1 (early in window mode), then normal kick at counter 3
    do_reset();
    set_in(2'b01, 2'b00, 2'b00, 2'b00);
    tick();
    tick();  // counter 1
    set_in(2'b01, 2'b01, 2'b00, 2'b00);
    tick();
    chk("t6 early trip", 32'(wif.trip), Window ? 32'h1 : 32'h0);
    chk("t6 early_kick", 32'(wif.early_kick), Window ? 32'h1 : 32'h0);
    if (Window) begin
      set_in(2'b01, 2'b00, 2'b01, 2'b00);
      tick();
      chk("t6 ek cleared", 32'(wif.early_kick), 32'h0);
    end
    set_in(2'b01, 2'b00, 2'b00, 2'b00);
    for (int c = 0; c < 3; c++) tick();  // counter 3
    set_in(2'b01, 2'b01, 2'b00, 2'b00);
    tick();
    chk("t6 normal trip", 32'(wif.trip), 32'h0);
    chk("t6 normal early_kick", 32'(wif.early_kick), 32'h0);
    set_in(2'b01, 2'b00, 2'b00, 2'b00);
    for (int k = 1; k <= WA; k++) begin
      tick();
      chk($sformatf("t6 warn k=%0d", k), 32'(wif.warn), (k == WA) ? 32'h1 : 32'h0);
    end

    // Randomized run against the reference model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      logic [1:0] en, hb, clr, ft;
      for (int b = 0; b < NCH; b++) begin
        en[b]  = ($urandom_range(99) < 96);
        hb[b]  = ($urandom_range(99) < 15);
        clr[b] = ($urandom_range(99) < 10);
        ft[b]  = ($urandom_range(99) < 2);
      end
      set_in(en, hb, clr, ft);
      tick();
      model_check("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
